uart_tx_datapath: RTL and testbench

//  Transmit datapath driven by the UART TX control unit. Holds the host byte in a

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_datapath.sv | 67 ++++++
 tb/tb_uart_tx_datapath.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants for the TX datapath and TX control unit.
// Frame geometry and line levels live here so both sides agree on them.
package uart_pkg;

  localparam int   UART_WORD_SIZE = 8;
  localparam int   UART_BC_SIZE   = 4;
  localparam logic UART_LINE_IDLE = 1'b1;
  localparam logic UART_START_BIT = 1'b0;

  // Shift count at which a frame is fully out (data bits plus stop bit).
  function automatic int uart_bc_max(input int word_size);
    return word_size + 1;
  endfunction

endpackage

// File: rtl/uart_tx_datapath.sv
// UART transmit datapath: data register, start/data/stop shifter and bit counter.
// All sequencing comes from the TX control unit through single-cycle strobes.
module uart_tx_datapath
  import uart_pkg::*;
#(
  parameter int WORD_SIZE = UART_WORD_SIZE,
  parameter int BC_SIZE   = UART_BC_SIZE
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic [WORD_SIZE-1:0] DATA_BUS,
  input  logic                 LOAD_XMT_DR,
  input  logic                 LOAD_XMT_SHFTREG,
  input  logic                 START,
  input  logic                 SHIFT,
  input  logic                 CLEAR,
  output logic                 SERIAL_OUT,
  output logic                 BC_LT_BCMAX,
  output logic                 TX_DONE
);

  localparam logic [BC_SIZE-1:0] BC_MAX = BC_SIZE'(uart_bc_max(WORD_SIZE));

  logic [WORD_SIZE-1:0] xmt_datareg;
  logic [WORD_SIZE:0]   xmt_shftreg;
  logic [BC_SIZE-1:0]   bit_count;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)
      xmt_datareg <= '0;
    else if (LOAD_XMT_DR)
      xmt_datareg <= DATA_BUS;
  end

  // Bit 0 is the line itself; ones refill from the top so the stop bit
  // and the idle level fall out of the shift naturally.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)
      xmt_shftreg <= '1;
    else if (LOAD_XMT_SHFTREG)
      xmt_shftreg <= {xmt_datareg, UART_LINE_IDLE};
    else if (START)
      xmt_shftreg[0] <= UART_START_BIT;
    else if (SHIFT)
      xmt_shftreg <= {UART_LINE_IDLE, xmt_shftreg[WORD_SIZE:1]};
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)
      bit_count <= '0;
    else if (CLEAR)
      bit_count <= '0;
    else if (SHIFT && bit_count < BC_MAX)
      bit_count <= bit_count + 1'b1;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)
      TX_DONE <= 1'b0;
    else
      TX_DONE <= CLEAR;
  end

  assign SERIAL_OUT  = xmt_shftreg[0];
  assign BC_LT_BCMAX = (bit_count < BC_MAX);

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Directed bench for uart_tx_datapath: reset, framing, load ordering,
// counter saturation, CLEAR/SHIFT collision and back-to-back frames.
module tb_uart_tx_datapath;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic [7:0] DATA_BUS;
  logic       LOAD_XMT_DR, LOAD_XMT_SHFTREG, START, SHIFT, CLEAR;
  logic       SERIAL_OUT, BC_LT_BCMAX, TX_DONE;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  uart_tx_datapath #(.WORD_SIZE(8), .BC_SIZE(4)) dut (
    .CLOCK            (CLOCK),
    .RESET            (RESET),
    .DATA_BUS         (DATA_BUS),
    .LOAD_XMT_DR      (LOAD_XMT_DR),
    .LOAD_XMT_SHFTREG (LOAD_XMT_SHFTREG),
    .START            (START),
    .SHIFT            (SHIFT),
    .CLEAR            (CLEAR),
    .SERIAL_OUT       (SERIAL_OUT),
    .BC_LT_BCMAX      (BC_LT_BCMAX),
    .TX_DONE          (TX_DONE)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes, sampled 1 time unit after the edge.
  task automatic cyc(input logic dr, input logic ls, input logic st,
                     input logic sh, input logic cl);
    LOAD_XMT_DR = dr; LOAD_XMT_SHFTREG = ls; START = st; SHIFT = sh; CLEAR = cl;
    @(posedge CLOCK);
    #1;
    LOAD_XMT_DR = 0; LOAD_XMT_SHFTREG = 0; START = 0; SHIFT = 0; CLEAR = 0;
    if (TX_DONE) done_cnt++;
  endtask

  logic [7:0] fdata [2];

  initial begin
    RESET = 1'b0; DATA_BUS = 8'h00;
    LOAD_XMT_DR = 0; LOAD_XMT_SHFTREG = 0; START = 0; SHIFT = 0; CLEAR = 0;
    #12;
    chk("rst_line", SERIAL_OUT, 1);
    chk("rst_bclt", BC_LT_BCMAX, 1);
    chk("rst_done", TX_DONE, 0);
    chk("rst_shft", dut.xmt_shftreg, 9'h1FF);
    RESET = 1'b1;

    // Reset mid-frame, while the line is low and TX_DONE is high
    @(posedge CLOCK); #1;
    DATA_BUS = 8'hA5;
    cyc(1,0,0,0,0);
    cyc(0,1,0,0,0);
    cyc(0,0,1,0,0);
    cyc(0,0,0,1,0);
    cyc(0,0,0,1,0);
    chk("mid_line_low", SERIAL_OUT, 0);
    cyc(0,0,0,0,1);
    chk("mid_done_hi", TX_DONE, 1);
    #2 RESET = 1'b0;
    #1;
    chk("mid_rst_line", SERIAL_OUT, 1);
    chk("mid_rst_bclt", BC_LT_BCMAX, 1);
    chk("mid_rst_done", TX_DONE, 0);
    #1 RESET = 1'b1;
    @(posedge CLOCK); #1;
    chk("post_rst_line", SERIAL_OUT, 1);

    // Frame 0xA5: line 0,1,0,1,0,0,1,0,1,1
    DATA_BUS = 8'hA5;
    cyc(1,0,0,0,0);
    cyc(0,1,0,0,0);
    chk("a5_loaded_idle", SERIAL_OUT, 1);
    cyc(0,0,1,0,0);
    chk("a5_start", SERIAL_OUT, 0);
    cyc(0,0,0,1,0); chk("a5_d0", SERIAL_OUT, 1);
    cyc(0,0,0,1,0); chk("a5_d1", SERIAL_OUT, 0);
    cyc(0,0,0,1,0); chk("a5_d2", SERIAL_OUT, 1);
    cyc(0,0,0,1,0); chk("a5_d3", SERIAL_OUT, 0);
    cyc(0,0,0,1,0); chk("a5_d4", SERIAL_OUT, 0);
    cyc(0,0,0,1,0); chk("a5_d5", SERIAL_OUT, 1);
    cyc(0,0,0,1,0); chk("a5_d6", SERIAL_OUT, 0);
    cyc(0,0,0,1,0); chk("a5_d7", SERIAL_OUT, 1);
    chk("a5_bclt_8", BC_LT_BCMAX, 1);
    cyc(0,0,0,1,0); chk("a5_stop", SERIAL_OUT, 1);
    chk("a5_bclt_9", BC_LT_BCMAX, 0);
    chk("a5_cnt_9", dut.bit_count, 9);
    cyc(0,0,0,0,1);
    chk("a5_done", TX_DONE, 1);
    chk("a5_bclt_clr", BC_LT_BCMAX, 1);
    cyc(0,0,0,0,0);
    chk("a5_done_drop", TX_DONE, 0);

    // Same-edge LOAD_XMT_DR and LOAD_XMT_SHFTREG
    DATA_BUS = 8'h81;
    cyc(1,0,0,0,0);
    DATA_BUS = 8'h3C;
    cyc(1,1,0,0,0);
    chk("ld_old_dr", dut.xmt_shftreg, 9'h103);
    cyc(0,1,0,0,0);
    chk("ld_new_dr", dut.xmt_shftreg, 9'h079);

    // Saturation: 12 shifts without CLEAR
    for (int i = 1; i <= 12; i++) begin
      cyc(0,0,0,1,0);
      if (i == 8) chk("sat_bclt_8", BC_LT_BCMAX, 1);
    end
    chk("sat_cnt", dut.bit_count, 9);
    chk("sat_bclt", BC_LT_BCMAX, 0);
    chk("sat_line", SERIAL_OUT, 1);
    chk("sat_shft", dut.xmt_shftreg, 9'h1FF);
    cyc(0,0,0,0,1);

    // CLEAR+SHIFT at bit_count=5 on 0x5A (d4=1, d5=0)
    DATA_BUS = 8'h5A;
    cyc(1,0,0,0,0);
    cyc(0,1,0,0,0);
    cyc(0,0,1,0,0);
    for (int i = 0; i < 5; i++) cyc(0,0,0,1,0);
    chk("cs_cnt5", dut.bit_count, 5);
    chk("cs_line_d4", SERIAL_OUT, 1);
    cyc(0,0,0,1,1);
    chk("cs_cnt0", dut.bit_count, 0);
    chk("cs_line_d5", SERIAL_OUT, 0);
    chk("cs_done", TX_DONE, 1);

    // START and SHIFT together: START wins, count still advances
    cyc(0,0,1,1,0);
    chk("ss_line", SERIAL_OUT, 0);
    chk("ss_cnt", dut.bit_count, 1);
    cyc(0,0,0,0,1);

    // Back-to-back 0x00 then 0xFF; next byte preloaded during first frame
    fdata[0] = 8'h00;
    fdata[1] = 8'hFF;
    DATA_BUS = fdata[0];
    cyc(1,0,0,0,0);
    cyc(0,1,0,0,0);
    done_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      cyc(0,0,1,0,0);
      chk($sformatf("b2b_f%0d_start", f), SERIAL_OUT, 0);
      for (int i = 1; i <= 9; i++) begin
        if (f == 0 && i == 1) begin
          DATA_BUS = fdata[1];
          cyc(1,0,0,1,0);
        end else begin
          cyc(0,0,0,1,0);
        end
        chk($sformatf("b2b_f%0d_bit%0d", f, i), SERIAL_OUT,
            (i <= 8) ? 32'(fdata[f][i-1]) : 32'd1);
      end
      chk($sformatf("b2b_f%0d_bclt", f), BC_LT_BCMAX, 0);
      cyc(0, (f == 0), 0, 0, 1);
      chk($sformatf("b2b_f%0d_done", f), TX_DONE, 1);
    end
    cyc(0,0,0,0,0);
    chk("b2b_done_pulses", done_cnt, 2);
    chk("b2b_idle", SERIAL_OUT, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
